div_seq: RTL and testbench
==========================

DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 The module SHALL have parameter DIVW, default 32, meaning operand/result width; only 32 is supported.
REQ-002 The module SHALL have port clk, input, 1, meaning the single rising-edge clock.
REQ-003 The module SHALL have port reset_n, input, 1, meaning the asynchronous, active-low reset.
REQ-004 The module SHALL have port start, input, 1, meaning a div/divu operation is present in EX.
REQ-005 The module SHALL have port signed_op, input, 1, meaning 1=div (two's complement), 0=divu.
REQ-006 The module SHALL have port annul, input, 1, meaning pipeline flush: cancel any operation.
REQ-007 The module SHALL have port dividend, input, 32, meaning the reg1 operand.
REQ-008 The module SHALL have port divisor, input, 32, meaning the reg2 operand.
REQ-009 The module SHALL have port stall_req, output, 1, meaning hold IF/ID/EX while high.
REQ-010 The module SHALL have port busy, output, 1, meaning the FSM is not in IDLE.
REQ-011 The module SHALL have port done, output, 1, meaning a one-cycle result-valid pulse and a HI/LO write strobe.
REQ-012 The module SHALL have port quotient, output, 32, meaning the LO write data.
REQ-013 The module SHALL have port remainder, output, 32, meaning the HI write data.
REQ-014 The module SHALL have port div_zero, output, 1, meaning the last result came from a zero divisor.

Function
REQ-015 The FSM SHALL have states IDLE, DZERO, RUN and DONE; done, busy and stall_req SHALL decode from the state register (no extra pipeline).
REQ-016 IDLE, start=1, annul=0, divisor==0: next state SHALL be DZERO.
REQ-017 IDLE, start=1, annul=0, divisor!=0: next state SHALL be RUN; on the same edge, |dividend|, |divisor|, sign bits and signed_op SHALL be latched and the step counter cleared; |x| SHALL equal x when signed_op=0.
REQ-018 RUN SHALL perform one restoring step per cycle: shift {rem,quo} left 1; if the shifted rem >= divisor, subtract it and set quo[0]=1.
REQ-019 The step counter SHALL be 6 bits; RUN SHALL go to DONE on the edge that completes step 32.
REQ-020 DZERO SHALL go to DONE after one cycle with quotient=0, remainder=0 and div_zero=1.
REQ-021 DONE SHALL go to IDLE unconditionally; start SHALL be ignored in DONE, and the requester drops start after seeing done.
REQ-022 On RUN->DONE, quotient SHALL be negated when signed_op=1 and the operand signs differ.
REQ-023 On RUN->DONE, remainder SHALL be negated when signed_op=1 and the dividend is negative; div_zero SHALL be cleared.
REQ-024 The signed case 0x80000000 / 0xFFFFFFFF SHALL yield quotient 0x80000000 and remainder 0 (wrap, no trap).
REQ-025 quotient, remainder and div_zero SHALL hold their values until the next entry to DONE.
REQ-026 stall_req SHALL equal (IDLE & start & ~annul) | DZERO | RUN; it SHALL be 0 in DONE so the pipeline advances during the done cycle.
REQ-027 busy SHALL be 1 in DZERO, RUN and DONE.
REQ-028 Latency: with start sampled at edge E0, done SHALL be high in the cycle after E32 for non-zero divisors and after E1 for zero divisors.
REQ-029 annul=1 in any state SHALL force next state IDLE without a done pulse and without updating quotient, remainder or div_zero; annul takes priority over start.
REQ-030 Operand inputs SHALL be ignored after the latch edge; changes during RUN SHALL have no effect.

Reset
REQ-031 reset_n=0 SHALL asynchronously force state=IDLE, counter=0, internal operand registers=0, done=0, busy=0, stall_req=0, quotient=0, remainder=0 and div_zero=0, including mid-RUN.
REQ-032 After reset_n rises, the first start SHALL be accepted on the first rising edge.

Verification
REQ-033 Unsigned case: divu 100/7 -> quotient=14, remainder=2, div_zero=0; stall_req high 33 cycles; done pulses once, 33 cycles after the start cycle.
REQ-034 Signed negative case: div -7/2 -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF; div 7/-2 -> quotient=0xFFFFFFFD, remainder=1.
REQ-035 Zero divisor: div 5/0 -> done in the 2nd cycle after the start cycle, quotient=0, remainder=0, div_zero=1; a following divu 9/3 -> quotient 3, remainder 0, div_zero=0.
REQ-036 Signed overflow: div 0x80000000/0xFFFFFFFF -> quotient=0x80000000, remainder=0; divu 0xFFFFFFFF/1 -> quotient=0xFFFFFFFF, remainder=0.
REQ-037 Annul: annul pulsed in RUN step 10 -> IDLE next cycle, no done, stall_req=0, outputs keep the previous result.
REQ-038 Mid-operation reset: reset_n low mid-RUN -> all outputs 0 immediately; a new start after release completes normally.

Source files
------------

// File: rtl/div_seq.sv
// div_seq: multi-cycle restoring divider for div/divu.
// Operands are latched on the start edge as magnitudes, and one quotient bit
// is produced per cycle. The result is sign-corrected as it is written to the
// output registers. A zero divisor takes a short path that produces 0/0 and
// sets div_zero.
//
// Ports
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   start      div/divu present in EX
//   signed_op  1 = signed div, 0 = divu
//   annul      pipeline flush; cancels any operation in flight
//   dividend   reg1 operand
//   divisor    reg2 operand
//   stall_req  hold IF/ID/EX while high
//   busy       FSM not in IDLE
//   done       one-cycle result-valid / HI-LO write strobe
//   quotient   LO write data
//   remainder  HI write data
//   div_zero   last result came from a zero divisor
//
// state | meaning
// ------+----------------------------------------------------
// IDLE  | waiting for start
// DZERO | zero divisor seen, result is forced on the next edge
// RUN   | one restoring step per cycle, 32 steps
// DONE  | result valid for one cycle, then back to IDLE
module div_seq #(
  parameter int DIVW = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic            signed_op,
  input  logic            annul,
  input  logic [DIVW-1:0] dividend,
  input  logic [DIVW-1:0] divisor,
  output logic            stall_req,
  output logic            busy,
  output logic            done,
  output logic [DIVW-1:0] quotient,
  output logic [DIVW-1:0] remainder,
  output logic            div_zero
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DZERO = 2'd1;
  localparam logic [1:0] RUN   = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [5:0]      cnt_q, cnt_d;
  logic [DIVW-1:0] rem_q, rem_d;
  logic [DIVW-1:0] quo_q, quo_d;
  logic [DIVW-1:0] dvs_q, dvs_d;
  logic            sgn_dvd_q, sgn_dvd_d;
  logic            sgn_dvs_q, sgn_dvs_d;
  logic            sop_q, sop_d;
  logic [DIVW-1:0] quot_q, quot_d;
  logic [DIVW-1:0] remo_q, remo_d;
  logic            dz_q, dz_d;

  logic [DIVW:0]   rem_sh;
  logic [DIVW:0]   diff;
  logic [DIVW-1:0] dvd_abs, dvs_abs;

  always_comb begin
    // |x| for signed ops; -0x80000000 wraps to itself, which is the
    // correct unsigned magnitude.
    dvd_abs = (signed_op && dividend[DIVW-1]) ? -dividend : dividend;
    dvs_abs = (signed_op && divisor[DIVW-1])  ? -divisor  : divisor;

    // The shifted partial remainder needs one extra bit; it is always
    // below 2*divisor, so the difference fits back into DIVW bits.
    rem_sh = {rem_q, quo_q[DIVW-1]};
    diff   = rem_sh - {1'b0, dvs_q};

    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    sgn_dvd_d = sgn_dvd_q;
    sgn_dvs_d = sgn_dvs_q;
    sop_d     = sop_q;
    quot_d    = quot_q;
    remo_d    = remo_q;
    dz_d      = dz_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (divisor == '0) begin
            state_d = DZERO;
          end else begin
            state_d   = RUN;
            cnt_d     = 6'd0;
            rem_d     = '0;
            quo_d     = dvd_abs;
            dvs_d     = dvs_abs;
            sgn_dvd_d = dividend[DIVW-1];
            sgn_dvs_d = divisor[DIVW-1];
            sop_d     = signed_op;
          end
        end
      end
      DZERO: begin
        state_d = DONE;
        quot_d  = '0;
        remo_d  = '0;
        dz_d    = 1'b1;
      end
      RUN: begin
        if (rem_sh >= {1'b0, dvs_q}) begin
          rem_d = diff[DIVW-1:0];
          quo_d = {quo_q[DIVW-2:0], 1'b1};
        end else begin
          rem_d = rem_sh[DIVW-1:0];
          quo_d = {quo_q[DIVW-2:0], 1'b0};
        end
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
          state_d = DONE;
          quot_d  = (sop_q && (sgn_dvd_q ^ sgn_dvs_q)) ? -quo_d : quo_d;
          remo_d  = (sop_q && sgn_dvd_q) ? -rem_d : rem_d;
          dz_d    = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Flush wins over everything: abandon the operation and leave the
    // visible result untouched.
    if (annul) begin
      state_d = IDLE;
      quot_d  = quot_q;
      remo_d  = remo_q;
      dz_d    = dz_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= 6'd0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      sgn_dvd_q <= 1'b0;
      sgn_dvs_q <= 1'b0;
      sop_q     <= 1'b0;
      quot_q    <= '0;
      remo_q    <= '0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      sgn_dvd_q <= sgn_dvd_d;
      sgn_dvs_q <= sgn_dvs_d;
      sop_q     <= sop_d;
      quot_q    <= quot_d;
      remo_q    <= remo_d;
      dz_q      <= dz_d;
    end
  end

  // The IDLE term of stall_req is combinational on start. It is gated by
  // reset_n so that stall_req stays low while reset is held.
  assign stall_req = reset_n &&
                     (((state_q == IDLE) && start && !annul) ||
                      (state_q == DZERO) || (state_q == RUN));
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign quotient  = quot_q;
  assign remainder = remo_q;
  assign div_zero  = dz_q;

endmodule

// File: tb/tb_div_seq.sv
// Testbench for div_seq. The stimulus has three parts:
//   - a table of directed vectors,
//   - randomized operations checked against an arithmetic reference model,
//   - hand-written annul and mid-operation reset sequences.
module tb_div_seq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        signed_op;
  logic        annul;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        stall_req;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_zero;

  int n_vec  = 0;
  int n_fail = 0;

  div_seq #(.DIVW(32)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .signed_op (signed_op),
    .annul     (annul),
    .dividend  (dividend),
    .divisor   (divisor),
    .stall_req (stall_req),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sop;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
  } vec_t;

  vec_t tbl[8];

  task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check1(input string nm, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  // Reference: plain integer division with C-style truncation.
  // A zero divisor gives 0/0 and sets the zero flag. The one signed
  // overflow case is defined to wrap.
  function automatic void model(input logic sop, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r, output logic dz);
    int sa;
    int sb;
    dz = 1'b0;
    if (b == 32'd0) begin
      q  = 32'd0;
      r  = 32'd0;
      dz = 1'b1;
    end else if (sop) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000;
        r = 32'd0;
      end else begin
        sa = a;
        sb = b;
        q  = sa / sb;
        r  = sa % sb;
      end
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Called just after a falling edge with the DUT idle. The task:
  //   - issues one operation and drops start after the accept edge,
  //   - scrambles the operand inputs every cycle while the DUT works,
  //   - checks latency, stall cycles, the result and the single done pulse.
  task automatic run_op(input logic sop, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eq, input logic [31:0] er, input logic edz,
                        input string nm);
    int lat;
    int stl;
    int exp_lat;
    bit seen;
    exp_lat   = (b == 32'd0) ? 2 : 33;
    signed_op = sop;
    dividend  = a;
    divisor   = b;
    annul     = 1'b0;
    start     = 1'b1;
    #1;
    check1({nm, " stall_at_start"}, stall_req, 1'b1);
    stl = 1;
    lat = 0;
    seen = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i <= 50 && !seen; i++) begin
      if (i > 1) @(negedge clk);
      dividend  = $urandom;
      divisor   = $urandom;
      signed_op = 1'($urandom_range(0, 1));
      #1;
      if (done) begin
        seen = 1'b1;
        lat  = i;
      end else if (stall_req) begin
        stl++;
      end
    end
    check32({nm, " latency"}, 32'(lat), 32'(exp_lat));
    check32({nm, " stall_cycles"}, 32'(stl), 32'(exp_lat));
    check32({nm, " quotient"}, quotient, eq);
    check32({nm, " remainder"}, remainder, er);
    check1({nm, " div_zero"}, div_zero, edz);
    check1({nm, " stall_in_done"}, stall_req, 1'b0);
    check1({nm, " busy_in_done"}, busy, 1'b1);
    @(negedge clk);
    #1;
    check1({nm, " done_single"}, done, 1'b0);
    check1({nm, " idle_after"}, busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic        rs;
    logic [31:0] ra, rb, rq, rr;
    logic        rdz;
    int          t;
    int          dcount;
    logic [31:0] prev_q, prev_r;

    tbl[0] = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
    tbl[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0};
    tbl[2] = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          1'b0};
    tbl[3] = '{1'b1, 32'd5,          32'd0,          32'd0,          32'd0,          1'b1};
    tbl[4] = '{1'b0, 32'd9,          32'd3,          32'd3,          32'd0,          1'b0};
    tbl[5] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0};
    tbl[6] = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0};
    tbl[7] = '{1'b0, 32'd3,          32'd10,         32'd0,          32'd3,          1'b0};

    reset_n   = 1'b0;
    start     = 1'b0;
    signed_op = 1'b0;
    annul     = 1'b0;
    dividend  = 32'd0;
    divisor   = 32'd0;
    #1;
    check1("reset busy", busy, 1'b0);
    check1("reset done", done, 1'b0);
    check1("reset stall", stall_req, 1'b0);
    check32("reset quotient", quotient, 32'd0);
    check32("reset remainder", remainder, 32'd0);
    check1("reset div_zero", div_zero, 1'b0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_op(tbl[i].sop, tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, tbl[i].dz,
             $sformatf("tbl%0d", i));
    end

    for (int k = 0; k < 20; k++) begin
      rs = 1'($urandom_range(0, 1));
      ra = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = $urandom_range(1, 15);
        2: begin
          t  = $urandom_range(1, 15);
          rb = 32'(-t);
        end
        3: begin
          ra = 32'h8000_0000;
          rb = $urandom_range(0, 1) ? 32'hFFFF_FFFF : $urandom;
        end
        default: rb = $urandom;
      endcase
      model(rs, ra, rb, rq, rr, rdz);
      run_op(rs, ra, rb, rq, rr, rdz, $sformatf("rnd%0d", k));
    end

    // Annul at step 10: the previous result must survive and no done
    // pulse may appear.
    run_op(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, "pre_annul");
    prev_q    = 32'd14;
    prev_r    = 32'd2;
    signed_op = 1'b0;
    dividend  = 32'd1000;
    divisor   = 32'd3;
    start     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int c = 2; c <= 10; c++) @(negedge clk);
    annul = 1'b1;
    @(posedge clk);
    @(negedge clk);
    annul = 1'b0;
    #1;
    check1("annul busy", busy, 1'b0);
    check1("annul stall", stall_req, 1'b0);
    check1("annul done", done, 1'b0);
    dcount = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      #1;
      if (done) dcount++;
    end
    check32("annul no_done", 32'(dcount), 32'd0);
    check32("annul keep_q", quotient, prev_q);
    check32("annul keep_r", remainder, prev_r);
    check1("annul keep_dz", div_zero, 1'b0);

    // Reset in the middle of RUN; then restart on the first edge after
    // release.
    @(negedge clk);
    signed_op = 1'b0;
    dividend  = 32'hFFFF;
    divisor   = 32'h10;
    start     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    start   = 1'b1;
    reset_n = 1'b0;
    #1;
    check1("midrst busy", busy, 1'b0);
    check1("midrst done", done, 1'b0);
    check1("midrst stall", stall_req, 1'b0);
    check32("midrst quotient", quotient, 32'd0);
    check32("midrst remainder", remainder, 32'd0);
    check1("midrst div_zero", div_zero, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    run_op(1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, "post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
